// File: rtl/adder_share_arb.sv
// Round-robin sequencer that time-shares one external add/sub unit among NREQ requesters.
// Optional build macro ADDER_SHARE_STATS_EN adds saturating grant/overflow counters.

//   state  | meaning
//   IDLE   | waiting for any req_valid; grants the round-robin winner
//   EXEC   | operands held on the shared adder while its ripple chain settles
//   RESP   | captured result presented until resp_ready
module adder_share_arb #(
  parameter int W    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ-1:0]   req_op,
  output logic [W-1:0]      add_x,
  output logic [W-1:0]      add_y,
  output logic              add_op,
  input  logic [W-1:0]      add_sum,
  input  logic              add_cout,
  input  logic              add_ovf,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_sum,
  output logic              resp_cout,
  output logic              resp_ovf
`ifdef ADDER_SHARE_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_ovf
`endif
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state;
  logic [PTRW-1:0] rr_ptr;
  logic [PTRW-1:0] win;
  logic [PTRW-1:0] win_hi;
  logic [PTRW-1:0] win_lo;
  logic            found_hi;
  logic            found_lo;
  logic            grant;
  logic [W-1:0]    win_x;
  logic [W-1:0]    win_y;
  logic            win_op;

  // Winner is the lowest valid index at or above the pointer, else the lowest valid overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = PTRW'(i);
      end
      if (req_valid[i] && (PTRW'(i) >= rr_ptr) && !found_hi) begin
        found_hi = 1'b1;
        win_hi   = PTRW'(i);
      end
    end
    win = found_hi ? win_hi : win_lo;
  end

  assign grant = (state == S_IDLE) && found_lo && !rst;

  always_comb begin
    req_ready = '0;
    win_x     = '0;
    win_y     = '0;
    win_op    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PTRW'(i)) begin
        req_ready[i] = grant;
        win_x        = req_x[i*W +: W];
        win_y        = req_y[i*W +: W];
        win_op       = req_op[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      add_x      <= '0;
      add_y      <= '0;
      add_op     <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
      resp_ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            add_x   <= win_x;
            add_y   <= win_y;
            add_op  <= win_op;
            resp_id <= IDW'(win);
            rr_ptr  <= (win == PTRW'(NREQ - 1)) ? '0 : win + PTRW'(1);
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          resp_sum   <= add_sum;
          resp_cout  <= add_cout;
          resp_ovf   <= add_ovf;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ADDER_SHARE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops <= '0;
      stat_ovf <= '0;
    end else begin
      if (grant && (stat_ops != 16'hFFFF))
        stat_ops <= stat_ops + 16'd1;
      if ((state == S_EXEC) && add_ovf && (stat_ovf != 16'hFFFF))
        stat_ovf <= stat_ovf + 16'd1;
    end
  end
`endif

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter/sequencer that time-shares one external 8-bit add/sub unit (X, Y, op_mode → SUM, C_out, Overflow) among NREQ requesters.
- Each requester issues an operation over a valid/ready handshake.
- The block drives the shared unit from registered operands and captures its flags.
- It returns a tagged response over a valid/ready handshake.
- Sits between client blocks and the single adder instance.

Parameters:
W, 8, operand/result width; must match the shared adder
NREQ, 4, number of requesters (2..8)
IDW, 2, response tag width; must satisfy 2**IDW >= NREQ

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot, one-cycle pulse
req_x  in  NREQ*W  packed X operands; requester i uses bits [i*W +: W]
req_y  in  NREQ*W  packed Y operands, same packing
req_op  in  NREQ  op_mode per requester: 0 = add, 1 = subtract (X−Y)
add_x  out  W  to shared adder X
add_y  out  W  to shared adder Y
add_op  out  1  to shared adder op_mode
add_sum  in  W  from shared adder SUM
add_cout  in  1  from shared adder C_out
add_ovf  in  1  from shared adder Overflow
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_id  out  IDW  index of the requester that owns the response
resp_sum  out  W  captured SUM
resp_cout  out  1  captured C_out
resp_ovf  out  1  captured Overflow

Behaviour:
- One clock, clk; reset rst is synchronous, active-high, and takes priority over every other action.
- Reset values: all outputs 0, rr pointer 0, FSM in IDLE. A reset mid-operation drops any in-flight or pending response silently; requesters must re-request.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching upward from the rr pointer, wrapping modulo NREQ.
  - In that cycle: req_ready[winner]=1 (combinational from state and req_valid), winner's operands and op are latched into add_x/add_y/add_op, winner index is latched into resp_id, rr pointer becomes (winner+1) mod NREQ, next state is EXEC.
  - If no req_valid is high, stay in IDLE; the pointer does not move.
- EXEC: one full cycle for the ripple adder to settle. At the clock edge, capture add_sum/add_cout/add_ovf into the resp_* outputs, set resp_valid=1, go to RESP.
- RESP:
  - Hold resp_* stable while resp_valid=1 and resp_ready=0.
  - On resp_valid && resp_ready: clear resp_valid, go to IDLE. No new grant happens in the same cycle.
- add_x/add_y/add_op hold their values until the next grant.
- req_ready is 0 outside IDLE. Requests arriving during EXEC/RESP wait; a requester must hold valid and operands stable until its ready pulse.
- Latency: grant at cycle t → resp_valid at t+2. Maximum throughput is one operation per 3 cycles with resp_ready tied high.
- Fairness: a continuously requesting client waits at most NREQ−1 grants.
- Simultaneous requests resolve by the pointer only; there is no fixed priority.
- The block does no arithmetic; the flags are exactly the shared adder's outputs.

Optional Feature:
ADDER_SHARE_STATS_EN
- Defined:
  - Adds output stat_ops (16 bits), which increments on every grant.
  - Adds output stat_ovf (16 bits), which increments when an Overflow=1 result is captured.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Single requester 0: X=125, Y=123, op=0 → req_ready[0] pulses; 2 cycles later resp_valid=1, resp_id=0, sum=248, cout=0, ovf=1.
- Requester 2: X=0, Y=255, op=1 → sum=1, cout=0, ovf=0, resp_id=2; X=73, Y=43, op=1 → sum=30, cout=1, ovf=0.
- All four requesters valid continuously, resp_ready=1 → grant order 0,1,2,3,0,…; exactly one ready bit per grant; a grant every 3 cycles.
- Backpressure: resp_ready=0 for 5 cycles after 25+23 → resp_sum=48 held stable, no further req_ready; release → one response only, then the next grant.
- Assert rst during EXEC with a pending request → all outputs 0 next cycle, pointer 0; the first grant after reset goes to the lowest-index valid requester.
- With ADDER_SHARE_STATS_EN defined: 3 ops including the 125+123 case → stat_ops=3, stat_ovf=1.
